// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit with lane select, extension and sub-word read-modify-write
module mem_access_unit #(
  parameter int unsigned MEM_BYTES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LH  = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b0011;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1000;
  localparam logic [3:0] OP_SH  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1011;

  state_t      state, state_next;
  logic [3:0]  op_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;

  logic        accept;
  logic        req_legal, req_misaligned, req_out_of_range, req_err;
  logic [32:0] req_last_byte;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_value, merged_word;

  assign accept     = req_valid && req_ready;
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE);
  // Strobes are gated by reset so an abort can never reach the RAM
  assign mem_read   = (state == READ)  && !reset;
  assign mem_write  = (state == WRITE) && !reset;

  // Classify the incoming request: legal opcode, natural alignment, word fully inside RAM
  always_comb begin
    req_legal = 1'b0;
    case (req_op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: req_legal = 1'b1;
      default: req_legal = 1'b0;
    endcase
    req_misaligned = 1'b0;
    if (req_op[1:0] == 2'b01) begin
      req_misaligned = req_addr[0];
    end else if (req_op[1:0] == 2'b11) begin
      req_misaligned = (req_addr[1:0] != 2'b00);
    end
    // 33 bits so addresses near 2^32 cannot wrap back into range
    req_last_byte    = {1'b0, req_addr[31:2], 2'b00} + 33'd3;
    req_out_of_range = (req_last_byte >= 33'(MEM_BYTES));
    req_err          = !req_legal || req_misaligned || req_out_of_range;
  end

  // Lane extraction and extension of the word returned by the RAM
  always_comb begin
    lane_byte  = mem_rdata[{lane_q, 3'b000} +: 8];
    lane_half  = mem_rdata[{lane_q[1], 4'b0000} +: 16];
    load_value = mem_rdata;
    case (op_q[2:0])
      3'b000:  load_value = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  load_value = {{16{lane_half[15]}}, lane_half};
      3'b100:  load_value = {24'd0, lane_byte};
      3'b101:  load_value = {16'd0, lane_half};
      default: load_value = mem_rdata;
    endcase
  end

  // Merge the store data into the old word, replacing only the target lane(s)
  always_comb begin
    merged_word = mem_rdata;
    if (op_q[1:0] == 2'b00) begin
      merged_word[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged_word[{lane_q[1], 4'b0000} +: 16] = wdata_q;
    end
  end

  // Next-state logic: errors skip memory, SW writes directly, SB/SH read first
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err) begin
            state_next = DONE;
          end else if (req_op == OP_SW) begin
            state_next = WRITE;
          end else begin
            state_next = READ;
          end
        end
      end
      READ:    state_next = op_q[3] ? WRITE : DONE;
      WRITE:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request latch, RAM address/data registers and held response
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= 4'd0;
      lane_q     <= 2'd0;
      wdata_q    <= 16'd0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      resp_rdata <= 32'd0;
      resp_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q      <= req_op;
            lane_q    <= req_addr[1:0];
            wdata_q   <= req_wdata[15:0];
            mem_addr  <= {req_addr[31:2], 2'b00};
            mem_wdata <= req_wdata;
            if (req_err) begin
              resp_error <= 1'b1;
              resp_rdata <= 32'd0;
            end
          end
        end
        READ: begin
          if (op_q[3]) begin
            mem_wdata <= merged_word;
          end else begin
            resp_rdata <= load_value;
            resp_error <= 1'b0;
          end
        end
        WRITE: begin
          resp_rdata <= 32'd0;
          resp_error <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit
module tb_mem_access_unit;

  localparam int MEM = 1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = 4'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  mem_access_unit #(.MEM_BYTES(MEM)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM behind the unit, and the reference byte image
  logic [7:0] ram [0:MEM-1];
  logic [7:0] model_mem [0:MEM-1];
  logic       load_all = 1'b0;
  logic [9:0] ra;
  assign ra = mem_addr[9:0];
  assign mem_rdata = (mem_addr <= 32'd996) ?
                     {ram[ra + 10'd3], ram[ra + 10'd2], ram[ra + 10'd1], ram[ra]} : 32'h0;

  always @(posedge clk) begin
    if (load_all) begin
      for (int i = 0; i < MEM; i++) ram[i] <= model_mem[i];
    end else if (mem_write && mem_addr <= 32'd996) begin
      ram[ra]         <= mem_wdata[7:0];
      ram[ra + 10'd1] <= mem_wdata[15:8];
      ram[ra + 10'd2] <= mem_wdata[23:16];
      ram[ra + 10'd3] <= mem_wdata[31:24];
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] ix(input int a);
    return a[9:0];
  endfunction

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
    int          nrd;
    int          nwr;
    logic [31:0] maddr;
    logic [31:0] wword;
  } exp_t;

  exp_t sb[$];

  // Reference: byte-array semantics of each opcode
  task automatic model(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       output exp_t e);
    int size;
    int base;
    logic legal;
    logic [31:0] v;
    e = '{default: 0};
    legal = op inside {4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hB};
    size = (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
    e.maddr = addr & ~32'h3;
    e.err = !legal || (addr % size != 0) || (longint'(e.maddr) + 3 >= MEM);
    if (e.err) begin
      e.lat = 1;
      return;
    end
    base = int'(e.maddr);
    if (op[3]) begin
      for (int i = 0; i < size; i++) model_mem[ix(int'(addr) + i)] = wd[8*i +: 8];
      e.wword = {model_mem[ix(base + 3)], model_mem[ix(base + 2)],
                 model_mem[ix(base + 1)], model_mem[ix(base)]};
      e.nwr = 1;
      e.nrd = (size < 4) ? 1 : 0;
      e.lat = (size < 4) ? 3 : 2;
    end else begin
      v = 32'd0;
      for (int i = 0; i < size; i++) v = v | (32'(model_mem[ix(int'(addr) + i)]) << (8 * i));
      if (!op[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8 * size)) - 32'd1);
      e.rdata = v;
      e.nrd = 1;
      e.lat = 2;
    end
  endtask

  // Monitor: strobe checks and response scoreboard
  logic [31:0] last_rdata = 32'd0;
  logic [31:0] last_wdata = 32'd0;
  logic        last_err = 1'b0;
  int rd_cnt = 0;
  int wr_cnt = 0;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      rd_cnt = 0;
      wr_cnt = 0;
    end else begin
      if (mem_read || mem_write) chk("strobe_overlap", 32'(mem_read & mem_write), 32'd0);
      if ((mem_read || mem_write) && sb.size() > 0) chk("mem_addr", mem_addr, sb[0].maddr);
      if (mem_write && sb.size() > 0) begin
        chk("mem_wdata", mem_wdata, sb[0].wword);
        last_wdata = mem_wdata;
      end
      rd_cnt += int'(mem_read);
      wr_cnt += int'(mem_write);
      if (resp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", 32'(resp_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_error", 32'(resp_error), 32'(e.err));
          chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
          chk("read_cycles", 32'(rd_cnt), 32'(e.nrd));
          chk("write_cycles", 32'(wr_cnt), 32'(e.nwr));
          last_rdata = resp_rdata;
          last_err = resp_error;
          rd_cnt = 0;
          wr_cnt = 0;
        end
      end
    end
  end

  task automatic sync_ram();
    @(negedge clk);
    load_all = 1'b1;
    @(negedge clk);
    load_all = 1'b0;
  endtask

  task automatic poke(input int a, input logic [7:0] d);
    model_mem[ix(a)] = d;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input bit keep, output int acc);
    exp_t e;
    int n;
    model(op, addr, wd, e);
    @(negedge clk);
    req_valid = 1'b1;
    req_op = op;
    req_addr = addr;
    req_wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    acc = cyc + 1;
    if (!req_ready) begin
      chk("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    e.acc = acc;
    @(posedge clk);
    sb.push_back(e);
    if (!keep) begin
      #1 req_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("resp_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, n, r, k;
    logic [3:0] ops [8];
    logic [3:0] op;
    logic [31:0] addr;
    ops = '{4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hB};

    for (int i = 0; i < MEM; i++) model_mem[ix(i)] = 8'($urandom);
    sync_ram();
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_error", 32'(resp_error), 32'd0);
    chk("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0;

    poke(16, 8'h78); poke(17, 8'h56); poke(18, 8'h34); poke(19, 8'h12);
    sync_ram();
    issue(4'h3, 32'h10, 32'h0, 0, a1); wait_idle();
    chk("lw_0x10", last_rdata, 32'h12345678);

    poke(19, 8'h80);
    sync_ram();
    issue(4'h0, 32'h13, 32'h0, 0, a1); wait_idle();
    chk("lb_0x13", last_rdata, 32'hFFFFFF80);
    issue(4'h4, 32'h13, 32'h0, 0, a1); wait_idle();
    chk("lbu_0x13", last_rdata, 32'h00000080);
    poke(18, 8'h34); poke(19, 8'h92);
    sync_ram();
    issue(4'h1, 32'h12, 32'h0, 0, a1); wait_idle();
    chk("lh_0x12", last_rdata, 32'hFFFF9234);
    issue(4'h5, 32'h12, 32'h0, 0, a1); wait_idle();
    chk("lhu_0x12", last_rdata, 32'h00009234);

    poke(32, 8'h44); poke(33, 8'h33); poke(34, 8'h22); poke(35, 8'h11);
    sync_ram();
    issue(4'h8, 32'h21, 32'hAABBCCDD, 0, a1); wait_idle();
    chk("sb_merge", last_wdata, 32'h1122DD44);
    issue(4'h3, 32'h20, 32'h0, 0, a1); wait_idle();
    chk("lw_after_sb", last_rdata, 32'h1122DD44);
    poke(32, 8'h44); poke(33, 8'h33); poke(34, 8'h22); poke(35, 8'h11);
    sync_ram();
    issue(4'h9, 32'h22, 32'h0000BEEF, 0, a1); wait_idle();
    chk("sh_merge", last_wdata, 32'hBEEF3344);

    issue(4'h3, 32'h2, 32'h0, 0, a1); wait_idle();
    chk("err_lw_misaligned", 32'(last_err), 32'd1);
    issue(4'h9, 32'h5, 32'h0, 0, a1); wait_idle();
    chk("err_sh_misaligned", 32'(last_err), 32'd1);
    issue(4'h3, 32'd1000, 32'h0, 0, a1); wait_idle();
    chk("err_out_of_range", 32'(last_err), 32'd1);
    issue(4'h2, 32'h0, 32'h0, 0, a1); wait_idle();
    chk("err_illegal_op", 32'(last_err), 32'd1);
    issue(4'h3, 32'd996, 32'h0, 0, a1); wait_idle();
    chk("lw_last_word_ok", 32'(last_err), 32'd0);

    issue(4'hB, 32'h40, 32'hDEADBEEF, 1, a1);
    issue(4'h3, 32'h40, 32'h0, 0, a2);
    wait_idle();
    chk("b2b_accept_gap", 32'(a2 - a1), 32'd3);
    chk("lw_after_sw", last_rdata, 32'hDEADBEEF);

    @(negedge clk);
    req_valid = 1'b1; req_op = 4'h8; req_addr = 32'h31; req_wdata = 32'h000000A5;
    n = 0;
    while (!req_ready && n < 10) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!mem_write && n < 10) begin @(negedge clk); n++; end
    chk("rmw_reached_write", 32'(mem_write), 32'd1);
    reset = 1'b1;
    #1 chk("reset_gates_write", 32'(mem_write), 32'd0);
    @(negedge clk);
    chk("reset_idle_ready", 32'(req_ready), 32'd1);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("after_reset_no_resp", 32'(resp_valid), 32'd0);
    chk("after_reset_ready", 32'(req_ready), 32'd1);
    issue(4'h3, 32'h30, 32'h0, 0, a1); wait_idle();

    for (int i = 0; i < 200; i++) begin
      k = int'($urandom_range(0, 7));
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom) : ops[k[2:0]];
      r = int'($urandom_range(0, 9));
      if (r < 7) addr = 32'($urandom_range(0, 127));
      else if (r < 9) addr = 32'(980 + $urandom_range(0, 30));
      else addr = $urandom;
      issue(op, addr, $urandom, 0, a1);
    end
    wait_idle();

    @(negedge clk);
    n = 0;
    for (int i = 0; i < MEM; i++) if (ram[i] !== model_mem[ix(i)]) n++;
    chk("ram_image_mismatches", 32'(n), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store unit between the CPU datapath and the byte-addressed data RAM, which reads and writes 4 bytes little-endian per access.
- Accepts one memory request at a time: LB, LBU, LH, LHU, LW, SB, SH or SW.
- Issues word-aligned RAM accesses only.
- Handles lane selection and sign/zero extension on loads.
- Performs read-modify-write for sub-word stores, because the RAM always writes all 4 bytes.
- Flags misaligned, out-of-range or illegal requests without touching memory.

Parameters:
MEM_BYTES, 1000, size of the RAM in bytes; an access whose aligned word would extend past MEM_BYTES-1 is an error.

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  unit idle; a request is accepted when req_valid && req_ready
req_op  in  4  MIPS opcode[3:0]: 0000 LB, 0001 LH, 0011 LW, 0100 LBU, 0101 LHU, 1000 SB, 1001 SH, 1011 SW
req_addr  in  32  byte address
req_wdata  in  32  store data (low byte/half used for SB/SH)
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  load result, extended; 0 for stores and errors
resp_error  out  1  valid with resp_valid: misaligned, out-of-range or illegal op
mem_addr  out  32  RAM address, always {addr[31:2],2'b00}
mem_wdata  out  32  RAM write data
mem_read  out  1  RAM read strobe; RAM returns data combinationally in the same cycle
mem_write  out  1  RAM write strobe; RAM commits while it is high
mem_rdata  in  32  RAM read data

Behaviour:
- Reset values: state IDLE; req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
- While reset is high, mem_read and mem_write are forced to 0 in the same cycle (gated, not just registered), so reset mid-operation never modifies RAM. The request is dropped and no resp_valid is produced.
- FSM states: IDLE, READ, WRITE, DONE.
  - req_ready=1 only in IDLE.
  - On accept, latch op, addr, wdata and compute the error flag.
- Error flag:
  - Error if op is not one of the 8 legal codes.
  - Error if LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - Error if {addr[31:2],2'b00}+3 >= MEM_BYTES.
  - On error: IDLE->DONE, no strobes, resp_error=1, resp_rdata=0.
- Transitions and latency from the accept edge (loads and SW take 2 cycles to resp_valid, SB/SH take 3, errors take 1):
  - Loads: IDLE->READ->DONE. mem_read=1 in READ; mem_rdata is captured at the end of READ.
  - SW: IDLE->WRITE->DONE. mem_write=1 in WRITE with mem_wdata=wdata.
  - SB/SH: IDLE->READ->WRITE->DONE.
    - READ captures the old word.
    - WRITE drives the merged word: only the target lane(s) are replaced, other bytes are unchanged.
  - DONE: resp_valid=1 for exactly one cycle, then IDLE. There is no response backpressure.
- mem_addr and mem_wdata are held stable for the whole READ/WRITE phase. Strobes are never high together.
- Lanes (little-endian):
  - Byte at addr[1:0]=k is bits [8k+7:8k].
  - Half at addr[1]=h is bits [16h+15:16h].
- Extension:
  - LB/LH sign-extend from bit 7/15 of the selected lane.
  - LBU/LHU zero-extend.
  - LW passes the word through unchanged.
- resp_rdata and resp_error hold their values until the next DONE; only resp_valid is a pulse.
- req_valid in non-IDLE states is ignored and not queued.
- Back-to-back: a new request can be accepted in the cycle after DONE.

Test Plan:
- Reset, then LW addr=0x10 with RAM bytes 0x10..0x13 = 78 56 34 12 -> mem_read for 1 cycle at mem_addr=0x10; resp_valid 2 cycles after accept; resp_rdata=0x12345678, resp_error=0.
- LB addr=0x13 (byte 0x80) -> resp_rdata=0xFFFFFF80. LBU at the same address -> 0x00000080. LH addr=0x12 with bytes 0x12..0x13 = 34 92 -> 0xFFFF9234. LHU -> 0x00009234.
- SB addr=0x21, wdata=0xAABBCCDD, old word 0x11223344 -> READ then WRITE at 0x20 with mem_wdata=0x1122DD44; subsequent LW 0x20 returns 0x1122DD44. SH addr=0x22 with wdata 0xBEEF on the same old word -> mem_wdata=0xBEEF3344.
- Errors, each giving resp_error=1 one cycle after accept, with no mem_read/mem_write at any point:
  - LW addr=0x2; SH addr=0x5; LW addr=996+4=1000 with MEM_BYTES=1000; op=0010.
- SW addr=0x40 wdata=0xDEADBEEF with req_valid held high throughout -> exactly one mem_write cycle; req_ready=0 during WRITE/DONE; the second request is accepted in the cycle after DONE.
- Assert reset during the WRITE cycle of an SB -> mem_write=0 in that cycle, RAM word unchanged, no resp_valid; IDLE with req_ready=1 on the next cycle.
